fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 Parameter QDEPTH, default 2: instruction queue entries; legal values 2 or 4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  instruction-memory request, registered.
REQ-006 imem_addr  out  32  word-aligned fetch address, registered; bits [1:0] always 0.
REQ-007 imem_ack  in  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-008 imem_rdata  in  32  instruction word, valid only when imem_ack=1.
REQ-009 branch_taken  in  1  redirect pulse from the control FSM.
REQ-010 branch_target  in  32  redirect address, sampled when branch_taken=1; bits [1:0] ignored.
REQ-011 instr_valid  out  1  queue head is valid.
REQ-012 instr_ready  in  1  decoder consumes the head when instr_valid&instr_ready.
REQ-013 instr  out  32  queue head word.
REQ-014 instr_pc  out  32  address the head word was fetched from.
REQ-015 cond/op/funct/rd  out  4/2/6/4  instr[31:28]/instr[27:26]/instr[25:20]/instr[15:12], combinational from instr.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DISCARD; reset enters IDLE; IDLE->FETCH unconditionally after one cycle.
REQ-017 In FETCH, imem_req SHALL be 1 whenever queue occupancy plus outstanding request is less than QDEPTH.
REQ-018 While imem_req=1 and imem_ack=0, imem_addr and imem_req SHALL hold stable.
REQ-019 On imem_ack in FETCH, {imem_rdata, imem_addr} SHALL be written to the queue tail; instr_valid rises the next cycle (1-cycle latency).
REQ-020 After an ack, the next imem_addr SHALL be the previous one +4 modulo 2^32 (32'hFFFF_FFFC wraps to 0); with space available, imem_req SHALL stay 1, giving one instruction per cycle on a zero-wait memory.
REQ-021 Queue SHALL be FIFO; push and pop in the same cycle SHALL be legal at any occupancy, leaving occupancy unchanged.
REQ-022 A push SHALL never occur when full (guaranteed by REQ-017); instr_valid SHALL be 0 when empty.
REQ-023 branch_taken SHALL flush the queue (instr_valid=0 next cycle) and load the fetch pointer with {branch_target[31:2],2'b00}.
REQ-024 branch_taken with no unacked request: next cycle imem_req=1, imem_addr=target, state FETCH.
REQ-025 branch_taken with imem_req=1 and imem_ack=0: enter DISCARD, keep old address and req until ack, drop that data, then fetch the target in the cycle after the ack.
REQ-026 branch_taken in the same cycle as imem_ack: the acked word SHALL be discarded, not queued.
REQ-027 branch_taken in the same cycle as a pop: the pop completes, then flush applies; redirect has priority over push.
REQ-028 branch_taken while in DISCARD SHALL replace the pending target; the latest target wins.

Reset
REQ-029 While reset=0: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, queue empty, state IDLE.
REQ-030 Reset asserted mid-request SHALL deassert imem_req immediately (asynchronous); any later imem_ack is ignored.

Configuration
REQ-031 Macro FETCH_PC8_EN: when defined, the module SHALL add output pc_plus8 (32) = instr_pc+8, the value the register file returns for r15; when undefined, the port and its adder SHALL be absent and all other behaviour is identical.

Verification
REQ-032 Reset release, zero-wait memory returning 32'hE0810002 at 0 -> imem_addr 0,4,8 on consecutive cycles; op=0, funct=6'b001000, rd=0, cond=4'hE at head.
REQ-033 instr_ready held 0, QDEPTH=2 -> exactly two acks, then imem_req=0 until a pop, after which one request at the next address.
REQ-034 Memory acks 3 cycles late, branch_taken with target 32'h0000_0100 during the wait -> DISCARD, stale word never reaches instr_valid, next imem_addr=32'h100.
REQ-035 branch_taken and imem_ack in the same cycle, target 32'h40 -> acked word dropped, queue empty, next imem_addr=32'h40.
REQ-036 Fetch pointer 32'hFFFF_FFFC acked -> next imem_addr=32'h0; with FETCH_PC8_EN, head at 32'hFFFF_FFFC gives pc_plus8=32'h4.
REQ-037 reset asserted with imem_req=1 and no ack -> imem_req=0 the same cycle; after release first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. A small FSM (IDLE / FETCH / DISCARD) issues
// word-aligned requests to instruction memory, pushes returned words together
// with their fetch address into a QDEPTH-entry FIFO, and presents the FIFO
// head to the decoder. A branch redirect flushes the FIFO and reloads the
// fetch pointer. If a request is still waiting for its ack when the redirect
// arrives, the FSM parks in DISCARD until that ack, drops the returned word,
// and then fetches the redirect target.
//
// Optional feature macro: FETCH_PC8_EN adds output pc_plus8 = instr_pc + 8.
//
// Handshakes:
//   imem: a request is held (req and addr stable) while imem_req=1 and
//         imem_ack=0. The request completes in a cycle where imem_req=1 and
//         imem_ack=1, and imem_rdata is valid in that same cycle.
//   instr: the head transfers in a cycle where instr_valid=1 and
//          instr_ready=1. instr_valid never depends on instr_ready.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   imem_req       registered instruction-memory request
//   imem_addr      registered word-aligned fetch address
//   imem_ack       memory accepts request, imem_rdata valid this cycle
//   imem_rdata     returned instruction word
//   branch_taken   redirect pulse
//   branch_target  redirect address (bits [1:0] ignored)
//   instr_valid    FIFO head valid
//   instr_ready    decoder consumes the head
//   instr          FIFO head word
//   instr_pc       address the head word came from
//   cond/op/funct/rd  field decode of instr
//   pc_plus8       instr_pc + 8 (only with FETCH_PC8_EN)
//   dbg_state      current FSM state (0=IDLE, 1=FETCH, 2=DISCARD)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
`ifdef FETCH_PC8_EN
    output logic [31:0] pc_plus8,
`endif
    output logic [1:0]  dbg_state
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [31:0]   r_target;

    logic [31:0]   r_q_instr [QDEPTH];
    logic [31:0]   r_q_pc    [QDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_ack;
    logic          w_push;
    logic [31:0]   w_target;
    logic [CW-1:0] w_count_next;
    logic          w_space;
    logic [1:0]    w_unused_bits;

    assign w_unused_bits = branch_target[1:0];

    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid & instr_ready;
    assign w_ack       = r_req & imem_ack;
    // Only FETCH pushes; a redirect in the ack cycle drops the word.
    assign w_push      = (r_state == S_FETCH) & w_ack & ~branch_taken;
    assign w_target    = {branch_target[31:2], 2'b00};

    // A redirect empties the queue; any same-cycle pop is subsumed by it.
    assign w_count_next = branch_taken ? '0
                        : (r_count + CW'(w_push) - CW'(w_pop));

    // Issue a new request only if its word is guaranteed a free slot.
    assign w_space = (w_count_next < CW'(QDEPTH));

    // -----------------------------------------------------------------------
    // Fetch FSM: owns imem_req / imem_addr and the pending redirect target.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_addr   <= {RESET_PC[31:2], 2'b00};
            r_target <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    if (branch_taken) begin
                        r_addr <= w_target;
                    end
                end
                S_FETCH: begin
                    if (branch_taken) begin
                        if (r_req && !imem_ack) begin
                            // Outstanding request must complete before redirect.
                            r_state  <= S_DISCARD;
                            r_target <= w_target;
                        end else begin
                            r_addr <= w_target;
                            r_req  <= 1'b1;
                        end
                    end else if (r_req && !imem_ack) begin
                        // Waiting for memory: hold request and address.
                        r_req  <= 1'b1;
                    end else begin
                        if (w_ack) begin
                            r_addr <= r_addr + 32'd4;
                        end
                        r_req <= w_space;
                    end
                end
                S_DISCARD: begin
                    if (branch_taken) begin
                        r_target <= w_target;
                    end
                    if (imem_ack) begin
                        r_state <= S_FETCH;
                        r_addr  <= branch_taken ? w_target : r_target;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Instruction FIFO: word plus fetch address per entry.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= 32'h0;
                r_q_pc[i]    <= 32'h0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (branch_taken) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_q_instr[r_wr_ptr] <= imem_rdata;
                    r_q_pc[r_wr_ptr]    <= r_addr;
                    r_wr_ptr            <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
            r_count <= w_count_next;
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign instr     = r_q_instr[r_rd_ptr];
    assign instr_pc  = r_q_pc[r_rd_ptr];
    assign cond      = instr[31:28];
    assign op        = instr[27:26];
    assign funct     = instr[25:20];
    assign rd        = instr[15:12];
    assign dbg_state = r_state;

`ifdef FETCH_PC8_EN
    assign pc_plus8 = instr_pc + 32'd8;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit (RESET_PC = 0, QDEPTH = 2). Inputs change and
// outputs are sampled 1 time unit after each rising clock edge. The memory
// model returns a fixed word per address.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
`ifdef FETCH_PC8_EN
  logic [31:0] pc_plus8;
`endif
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .cond          (cond),
    .op            (op),
    .funct         (funct),
    .rd            (rd),
`ifdef FETCH_PC8_EN
    .pc_plus8      (pc_plus8),
`endif
    .dbg_state     (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory contents: a known instruction at 0, address-derived words elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'hE081_0002 : (a ^ 32'h5A5A_0000);
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset         = 1'b0;
    imem_ack      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    instr_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // ---- reset state ----
    reset         = 1'b0;
    imem_ack      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    instr_ready   = 1'b0;
    tick();
    chk("rst_req",   {31'b0, imem_req},    32'h0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr,                32'h0);
    chk("rst_pc",    instr_pc,             32'h0);
    chk("rst_state", {30'b0, dbg_state},   32'h0);

    // ---- zero-wait streaming, decoder always ready ----
    apply_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("s_e1_state", {30'b0, dbg_state},   32'h1);
    chk("s_e1_req",   {31'b0, imem_req},    32'h1);
    chk("s_e1_addr",  imem_addr,            32'h0);
    chk("s_e1_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("s_e2_addr",  imem_addr,            32'h4);
    chk("s_e2_valid", {31'b0, instr_valid}, 32'h1);
    chk("s_e2_instr", instr,                32'hE081_0002);
    chk("s_e2_pc",    instr_pc,             32'h0);
    chk("s_e2_cond",  {28'b0, cond},        32'hE);
    chk("s_e2_op",    {30'b0, op},          32'h0);
    chk("s_e2_funct", {26'b0, funct},       32'h8);
    chk("s_e2_rd",    {28'b0, rd},          32'h0);
    tick();
    chk("s_e3_addr",  imem_addr,            32'h8);
    chk("s_e3_pc",    instr_pc,             32'h4);
    chk("s_e3_instr", instr,                32'h5A5A_0004);
    tick();
    chk("s_e4_addr",  imem_addr,            32'hC);
    chk("s_e4_pc",    instr_pc,             32'h8);

    // ---- back-pressure: queue fills after two acks ----
    apply_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b0;
    tick();
    chk("bp_e1_addr", imem_addr,         32'h0);
    tick();
    chk("bp_e2_req",  {31'b0, imem_req}, 32'h1);
    chk("bp_e2_addr", imem_addr,         32'h4);
    tick();
    chk("bp_e3_req",  {31'b0, imem_req}, 32'h0);
    chk("bp_e3_addr", imem_addr,         32'h8);
    chk("bp_e3_pc",   instr_pc,          32'h0);
    tick();
    chk("bp_e4_req",  {31'b0, imem_req}, 32'h0);
    chk("bp_e4_pc",   instr_pc,          32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("bp_e5_req",  {31'b0, imem_req}, 32'h1);
    chk("bp_e5_addr", imem_addr,         32'h8);
    chk("bp_e5_pc",   instr_pc,          32'h4);
    tick();
    chk("bp_e6_req",  {31'b0, imem_req}, 32'h0);
    chk("bp_e6_addr", imem_addr,         32'hC);
    chk("bp_e6_pc",   instr_pc,          32'h4);

    // ---- late ack with redirect during the wait ----
    apply_reset();
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    tick();
    branch_taken = 1'b0;
    chk("la_e2_state", {30'b0, dbg_state}, 32'h2);
    chk("la_e2_req",   {31'b0, imem_req},  32'h1);
    chk("la_e2_addr",  imem_addr,          32'h0);
    tick();
    chk("la_e3_addr",  imem_addr,          32'h0);
    imem_ack = 1'b1;
    tick();
    chk("la_e4_state", {30'b0, dbg_state},   32'h1);
    chk("la_e4_addr",  imem_addr,            32'h100);
    chk("la_e4_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("la_e5_valid", {31'b0, instr_valid}, 32'h1);
    chk("la_e5_pc",    instr_pc,             32'h100);

    // ---- second redirect while discarding: latest target wins ----
    apply_reset();
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    tick();
    branch_target = 32'h0000_0204;
    tick();
    branch_taken = 1'b0;
    chk("lw_e3_state", {30'b0, dbg_state}, 32'h2);
    chk("lw_e3_addr",  imem_addr,          32'h0);
    imem_ack = 1'b1;
    tick();
    chk("lw_e4_addr",  imem_addr,          32'h204);
    tick();
    chk("lw_e5_pc",    instr_pc,           32'h204);

    // ---- redirect in the same cycle as an ack ----
    apply_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b0;
    tick();
    tick();
    chk("ba_e2_valid", {31'b0, instr_valid}, 32'h1);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0043;
    tick();
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
    chk("ba_e3_valid", {31'b0, instr_valid}, 32'h0);
    chk("ba_e3_addr",  imem_addr,            32'h40);
    chk("ba_e3_req",   {31'b0, imem_req},    32'h1);
    tick();
    chk("ba_e4_valid", {31'b0, instr_valid}, 32'h0);
    chk("ba_e4_addr",  imem_addr,            32'h40);

    // ---- address wrap at the top of memory ----
    apply_reset();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    imem_ack      = 1'b1;
    tick();
    branch_taken = 1'b0;
    chk("wr_e2_addr",  imem_addr,            32'hFFFF_FFFC);
    tick();
    chk("wr_e3_addr",  imem_addr,            32'h0);
    chk("wr_e3_valid", {31'b0, instr_valid}, 32'h1);
    chk("wr_e3_pc",    instr_pc,             32'hFFFF_FFFC);
`ifdef FETCH_PC8_EN
    chk("wr_e3_pc8",   pc_plus8,             32'h4);
`endif

    // ---- asynchronous reset during an outstanding request ----
    apply_reset();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0080;
    imem_ack      = 1'b1;
    tick();
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
    tick();
    chk("ar_hold_req",  {31'b0, imem_req}, 32'h1);
    chk("ar_hold_addr", imem_addr,         32'h80);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_async_req",   {31'b0, imem_req},  32'h0);
    chk("ar_async_addr",  imem_addr,          32'h0);
    chk("ar_async_state", {30'b0, dbg_state}, 32'h0);
    imem_ack = 1'b1;
    tick();
    tick();
    chk("ar_in_rst_req",   {31'b0, imem_req},    32'h0);
    chk("ar_in_rst_valid", {31'b0, instr_valid}, 32'h0);
    reset    = 1'b1;
    imem_ack = 1'b0;
    tick();
    chk("ar_rel_req",  {31'b0, imem_req}, 32'h1);
    chk("ar_rel_addr", imem_addr,         32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
